// File: rtl/split_gen_pkg.sv
// Shared types, constants and helpers for the split-checker candidate generator.
// The LFSR step function lives here so the register and the chunk writer agree.
package split_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_CHECK,
    ST_HOLD,
    ST_FAIL
  } state_e;

  localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;
  localparam logic [31:0] LFSR_RESET = 32'h0000_0001;

  localparam int unsigned DEF_VEC_W     = 307;
  localparam int unsigned DEF_MAX_TRIES = 16;

  function automatic int unsigned nchunk(input int unsigned w);
    return (w + 32'd31) / 32'd32;
  endfunction

  // Galois right-shift step.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

// File: rtl/split_lfsr32.sv
// 32-bit Galois LFSR with seed load; a zero seed is replaced by the reset value
// so the register can never lock up.
module split_lfsr32
  import split_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state
);

  logic [31:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (seed == '0) ? LFSR_RESET : seed;
    end else if (step) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LFSR_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/split_candidate_gen.sv
// Builds LFSR candidates for a split constraint checker, retries until the checker
// accepts or the try budget is spent, and hands accepted vectors downstream.
module split_candidate_gen
  import split_gen_pkg::*;
#(
  parameter int unsigned VEC_W     = DEF_VEC_W,
  parameter int unsigned MAX_TRIES = DEF_MAX_TRIES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             seed_load,
  input  logic [31:0]      seed,
  output logic [VEC_W-1:0] cand_vec,
  output logic             cand_valid,
  input  logic             chk_result,
  output logic [VEC_W-1:0] sample_vec,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             fail,
  output logic             busy,
  output logic [7:0]       tries
);

  localparam int unsigned NCHUNK = nchunk(VEC_W);
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned LAST_W = VEC_W - 32 * (NCHUNK - 1);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    chunk_q, chunk_d;
  logic [7:0]       tries_q, tries_d;
  logic [VEC_W-1:0] cand_q, cand_d;
  logic [VEC_W-1:0] sample_q, sample_d;

  logic        lfsr_load, lfsr_step;
  logic [31:0] lfsr_state, lfsr_nxt;

  split_lfsr32 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (seed),
    .step  (lfsr_step),
    .state (lfsr_state)
  );

  // Chunks are written with the value the LFSR holds after this cycle's step.
  assign lfsr_nxt = lfsr_next(lfsr_state);

  always_comb begin
    state_d   = state_q;
    chunk_d   = chunk_q;
    tries_d   = tries_q;
    cand_d    = cand_q;
    sample_d  = sample_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    case (state_q)
      ST_IDLE: begin
        lfsr_load = seed_load;
        if (start) begin
          state_d = ST_FILL;
          tries_d = '0;
          chunk_d = '0;
        end
      end

      ST_FILL: begin
        lfsr_step = 1'b1;
        for (int unsigned k = 0; k < NCHUNK - 1; k++) begin
          if (chunk_q == CW'(k)) begin
            cand_d[k*32 +: 32] = lfsr_nxt;
          end
        end
        if (chunk_q == LAST_CHUNK) begin
          cand_d[VEC_W-1 -: LAST_W] = lfsr_nxt[LAST_W-1:0];
          state_d = ST_CHECK;
        end else begin
          chunk_d = chunk_q + CW'(1);
        end
      end

      ST_CHECK: begin
        tries_d = tries_q + 8'd1;
        if (chk_result) begin
          sample_d = cand_q;
          state_d  = ST_HOLD;
        end else if (tries_d == 8'(MAX_TRIES)) begin
          state_d = ST_FAIL;
        end else begin
          state_d = ST_FILL;
          chunk_d = '0;
        end
      end

      ST_HOLD: begin
        if (sample_ready) begin
          state_d = ST_IDLE;
        end
      end

      ST_FAIL: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      chunk_q  <= '0;
      tries_q  <= '0;
      cand_q   <= '0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      chunk_q  <= chunk_d;
      tries_q  <= tries_d;
      cand_q   <= cand_d;
      sample_q <= sample_d;
    end
  end

  assign cand_vec     = cand_q;
  assign sample_vec   = sample_q;
  assign tries        = tries_q;
  assign cand_valid   = (state_q == ST_CHECK);
  assign sample_valid = (state_q == ST_HOLD);
  assign fail         = (state_q == ST_FAIL);
  assign busy         = (state_q != ST_IDLE);

endmodule
